seq_slice_alu: RTL and testbench

Multi-cycle bit-slice ALU that computes a WIDTH-bit result SLICE bits per clock, LSB slice first, and produces the overflow, zero and carry flags. It sits directly upstream of the 32-bit result/flag register. Its `result`, `overflow`, `zero` and `carry` outputs drive that register's `d`, `overflow`, `zero` and `carry` inputs. The downstream register captures them on the cycle `done` is high.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_slice.sv | 42 ++++
 rtl/seq_slice_alu.sv | 149 ++++++++++++++
 tb/tb_seq_slice_alu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential bit-slice ALU: op codes, default
// geometry and the op-code type.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND = 3'b000;
    localparam op_t OP_OR  = 3'b001;
    localparam op_t OP_XOR = 3'b010;
    localparam op_t OP_NOR = 3'b011;
    localparam op_t OP_ADD = 3'b100;
    localparam op_t OP_SUB = 3'b101;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; time-multiplexed by seq_slice_alu.
// cmsb is the carry into the slice MSB, used to derive signed overflow.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_t              op,
    input  logic             cin,
    output logic [SLICE-1:0] r,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE-1:0] beff_s;
    logic [SLICE:0]   sum_s;

    // Slice datapath: adder for ADD/SUB, bitwise logic otherwise
    always_comb begin
        beff_s = (op == OP_SUB) ? ~b : b;
        sum_s  = {1'b0, a} + {1'b0, beff_s} + {{SLICE{1'b0}}, cin};
        r      = {SLICE{1'b0}};
        cout   = 1'b0;
        cmsb   = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_ADD, OP_SUB: begin
                r    = sum_s[SLICE-1:0];
                cout = sum_s[SLICE];
                // Carry into the MSB recovered from the MSB sum bit
                cmsb = a[SLICE-1] ^ beff_s[SLICE-1] ^ sum_s[SLICE-1];
            end
            default: r = {SLICE{1'b0}};
        endcase
    end

endmodule

// File: rtl/seq_slice_alu.sv
// Multi-cycle ALU: processes WIDTH bits SLICE per clock, LSB slice first,
// and registers result and flags on the cycle done pulses.
module seq_slice_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             carry
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
    op_t                    op_q, op_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   cin_q, cin_d, nz_q, nz_d;
    logic [WIDTH-SLICE-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]       acc_full_s;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   ovf_q, ovf_d, zero_q, zero_d, carry_q, carry_d;
    logic [SLICE-1:0]       slice_r_s;
    logic                   slice_cout_s, slice_cmsb_s;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .op   (op_q),
        .cin  (cin_q),
        .r    (slice_r_s),
        .cout (slice_cout_s),
        .cmsb (slice_cmsb_s)
    );

    // Next-state logic for the FSM, datapath and output registers
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        cin_d      = cin_q;
        nz_d       = nz_q;
        acc_d      = acc_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        // New slice enters at the top so the last slice lands in the MSBs
        acc_full_s = {slice_r_s, acc_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = {CW{1'b0}};
                    cin_d   = (op == OP_SUB);
                    nz_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                cin_d = slice_cout_s;
                nz_d  = nz_q | (|slice_r_s);
                acc_d = acc_full_s[WIDTH-1:SLICE];
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = acc_full_s;
                    ovf_d    = slice_cmsb_s ^ slice_cout_s;
                    zero_d   = ~nz_d;
                    carry_d  = slice_cout_s;
                end else begin
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= OP_AND;
            cnt_q    <= {CW{1'b0}};
            cin_q    <= 1'b0;
            nz_q     <= 1'b0;
            acc_q    <= {(WIDTH-SLICE){1'b0}};
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            cin_q    <= cin_d;
            nz_q     <= nz_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign carry    = carry_q;

endmodule

// File: tb/tb_seq_slice_alu.sv
// Directed self-checking bench for seq_slice_alu with hand-computed vectors.
module tb_seq_slice_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start;
    op_t         op;
    logic [31:0] a, b, result;
    logic        busy, done, overflow, zero, carry;
    int          n_tests = 0;
    int          n_fail  = 0;

    seq_slice_alu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .overflow(overflow), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    // Issue one start at the next edge, then count edges until done (bounded).
    task automatic run_op(input op_t o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = OP_AND; a = 32'h0; b = 32'h0;
        #12;
        n_tests++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_ctl: got %b want 00", {busy, done}); end
        n_tests++;
        if (result !== 32'h0 || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL reset_out: got %h/%b want 0/000", result, {overflow, zero, carry});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int cyc;
        run_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, cyc);
        n_tests++;
        if (cyc !== 8) begin n_fail++; $display("FAIL add_ovf_latency: got %0d want 8", cyc); end
        n_tests++;
        if (result !== 32'h80000000 || {overflow, zero, carry} !== 3'b100) begin
            n_fail++; $display("FAIL add_ovf: got %h/%b want 80000000/100", result, {overflow, zero, carry});
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", done); end
        run_op(OP_ADD, 32'hFFFFFFFF, 32'h00000001, cyc);
        n_tests++;
        if (cyc !== 8 || result !== 32'h0 || {overflow, zero, carry} !== 3'b011) begin
            n_fail++; $display("FAIL add_carry_zero: got %0d/%h/%b want 8/00000000/011", cyc, result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int cyc;
        run_op(OP_SUB, 32'd5, 32'd5, cyc);
        n_tests++;
        if (cyc !== 8 || result !== 32'h0 || {overflow, zero, carry} !== 3'b011) begin
            n_fail++; $display("FAIL sub_equal: got %0d/%h/%b want 8/00000000/011", cyc, result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
        run_op(OP_SUB, 32'd3, 32'd5, cyc);
        n_tests++;
        if (result !== 32'hFFFFFFFE || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL sub_borrow: got %h/%b want FFFFFFFE/000", result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_logic();
        int cyc;
        run_op(OP_XOR, 32'hA5A5A5A5, 32'hFFFF0000, cyc);
        n_tests++;
        if (result !== 32'h5A5AA5A5 || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL xor: got %h/%b want 5A5AA5A5/000", result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
        run_op(OP_NOR, 32'hFFFFFFFF, 32'h0, cyc);
        n_tests++;
        if (result !== 32'h0 || {overflow, zero, carry} !== 3'b010) begin
            n_fail++; $display("FAIL nor: got %h/%b want 00000000/010", result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
        run_op(OP_ADD, 32'hFFFFFFFF, 32'h00000001, cyc);
        @(posedge clk); #1;
        run_op(3'b111, 32'h12345678, 32'h9ABCDEF0, cyc);
        n_tests++;
        if (cyc !== 8 || result !== 32'h0 || {overflow, zero, carry} !== 3'b010) begin
            n_fail++; $display("FAIL reserved_op: got %0d/%h/%b want 8/00000000/010", cyc, result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_handling();
        int cyc;
        run_op(OP_OR, 32'h12340000, 32'h00005678, cyc);
        n_tests++;
        if (result !== 32'h12345678 || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL or: got %h/%b want 12345678/000", result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
        start = 1'b1; op = OP_SUB; a = 32'd10; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1; start = 1'b0;
        n_tests++;
        if (result !== 32'h12345678 || busy !== 1'b1) begin
            n_fail++; $display("FAIL hold_in_busy: got %h/%b want 12345678/1", result, busy);
        end
        cyc = 3;
        while (done !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc !== 8 || result !== 32'd7 || {overflow, zero, carry} !== 3'b001) begin
            n_fail++; $display("FAIL start_in_busy: got %0d/%h/%b want 8/00000007/001", cyc, result, {overflow, zero, carry});
        end
        // Back-to-back start issued in the done cycle
        start = 1'b1; op = OP_AND; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
        @(posedge clk); #1; start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || result !== 32'd7) begin
            n_fail++; $display("FAIL b2b_accept: got %b/%b/%h want 0/1/00000007", done, busy, result);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc !== 8 || result !== 32'h00F000F0 || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_result: got %0d/%h/%b want 8/00F000F0/000", cyc, result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        start = 1'b1; op = OP_ADD; a = 32'hFFFFFFFF; b = 32'h00000001;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done} !== 2'b00 || result !== 32'h0 || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL reset_async: got %b/%h/%b want 00/00000000/000", {busy, done}, result, {overflow, zero, carry});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard: got %b/%b want 0/0", busy, done);
        end
        run_op(OP_ADD, 32'd1, 32'd2, cyc);
        n_tests++;
        if (cyc !== 8 || result !== 32'd3 || {overflow, zero, carry} !== 3'b000) begin
            n_fail++; $display("FAIL add_after_reset: got %0d/%h/%b want 8/00000003/000", cyc, result, {overflow, zero, carry});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_start_handling();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
